// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-based up/down modulo counter.
// Holds the JK action encoding, the default sizing and the next-state mode type.
package jk_updown_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_MOD   = 10;

  // {J,K} action encoding
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_UP   = 2'd2,
    MODE_DOWN = 2'd3
  } count_mode_e;

endpackage

// File: rtl/jk_updown_counter_cell.sv
// Single JK storage cell: one count bit with complementary output.
// Resets asynchronously to Q=0 / Q_n=1.
module jk_cell
  import jk_updown_counter_pkg::*;
(
  input  logic CLK,
  input  logic RST_n,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_n
);

  logic q_reg;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      q_reg <= 1'b0;
    end else begin
      case ({J, K})
        JK_HOLD: q_reg <= q_reg;
        JK_CLR:  q_reg <= 1'b0;
        JK_SET:  q_reg <= 1'b1;
        default: q_reg <= ~q_reg;
      endcase
    end
  end

  assign Q   = q_reg;
  assign Q_n = ~q_reg;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK cells; the top level only
// generates per-bit J/K, load clamping and the combinational terminal count.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             TC
);

  // One extra bit so MOD == 2**WIDTH is representable
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MOD - 1);

  count_mode_e      mode;
  logic             illegal;
  logic             at_max;
  logic             at_zero;
  logic             explicit_set;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic [WIDTH-1:0] tgl_bus;
  logic [WIDTH-1:0] j_bus;
  logic [WIDTH-1:0] k_bus;

  assign illegal = {1'b0, Q} >= MOD_EXT;
  assign at_max  = (Q == MAX_COUNT);
  assign at_zero = (Q == '0);
  assign TC      = EN & ~LOAD & ((UP & at_max) | (~UP & at_zero));

  always_comb begin
    mode = MODE_HOLD;
    if (LOAD) begin
      mode = MODE_LOAD;
    end else if (EN) begin
      mode = UP ? MODE_UP : MODE_DOWN;
    end
  end

  // Loads, wraps and recovery from an out-of-range count all force every bit
  // to an explicit target; ordinary counting uses the toggle chain instead.
  always_comb begin
    target       = '0;
    explicit_set = 1'b0;
    case (mode)
      MODE_LOAD: begin
        explicit_set = 1'b1;
        target       = ({1'b0, D} < MOD_EXT) ? D : MAX_COUNT;
      end
      MODE_UP: begin
        if (at_max || illegal) begin
          explicit_set = 1'b1;
          target       = '0;
        end
      end
      MODE_DOWN: begin
        if (at_zero || illegal) begin
          explicit_set = 1'b1;
          target       = MAX_COUNT;
        end
      end
      default: begin
        explicit_set = 1'b0;
        target       = '0;
      end
    endcase
  end

  assign ones_below[0]  = 1'b1;
  assign zeros_below[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign ones_below[gi]  = ones_below[gi-1] & Q[gi-1];
      assign zeros_below[gi] = zeros_below[gi-1] & ~Q[gi-1];
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign tgl_bus[gi] = (mode == MODE_UP)   ? ones_below[gi]  :
                           (mode == MODE_DOWN) ? zeros_below[gi] : 1'b0;
      assign j_bus[gi]   = explicit_set ? target[gi]  : tgl_bus[gi];
      assign k_bus[gi]   = explicit_set ? ~target[gi] : tgl_bus[gi];

      jk_cell u_cell (
        .CLK   (CLK),
        .RST_n (RST_n),
        .J     (j_bus[gi]),
        .K     (k_bus[gi]),
        .Q     (Q[gi]),
        .Q_n   (Q_n[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_jk_updown_counter.sv
// Scoreboard bench for jk_updown_counter (WIDTH=4, MOD=10): directed scenarios
// followed by random traffic, checked against an arithmetic model.
module tb_jk_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         tc;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic [W-1:0] j;
    logic [W-1:0] k;
  } exp_t;

  exp_t sb[$];
  int   model_q;
  int   n_checks;
  int   n_fail;
  int   n_txn;

  jk_updown_counter #(.WIDTH(W), .MOD(M)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .EN    (en),
    .UP    (up),
    .LOAD  (load),
    .D     (d),
    .Q     (q),
    .Q_n   (q_n),
    .TC    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (txn %0d)", name, act, exp, n_txn);
    end
  endtask

  // Apply one cycle of inputs after the active edge and queue what the DUT must show.
  task automatic step(input logic r, input logic e, input logic u, input logic l, input int dv);
    exp_t x;
    int   nxt;
    bit   forced;
    @(posedge clk);
    #1;
    rst_n = r; en = e; up = u; load = l; d = W'(dv);
    if (!r) model_q = 0;
    forced = 1'b0;
    nxt    = model_q;
    if (l) begin
      forced = 1'b1;
      nxt    = (dv < M) ? dv : M - 1;
    end else if (e && u) begin
      if (model_q >= M - 1) begin forced = 1'b1; nxt = 0; end
      else nxt = model_q + 1;
    end else if (e) begin
      if (model_q == 0 || model_q >= M) begin forced = 1'b1; nxt = M - 1; end
      else nxt = model_q - 1;
    end
    x.q  = W'(model_q);
    x.tc = e && !l && ((u && model_q == M - 1) || (!u && model_q == 0));
    if (forced) begin
      x.j = W'(nxt);
      x.k = ~W'(nxt);
    end else begin
      // A bit flips exactly when it toggles; unchanged bits hold.
      x.j = W'(model_q) ^ W'(nxt);
      x.k = W'(model_q) ^ W'(nxt);
    end
    sb.push_back(x);
    model_q = r ? nxt : 0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_txn++;
        $display("txn %0d: rst_n=%0b en=%0b up=%0b load=%0b d=%0d -> Q=%0d Q_n=%b TC=%0b J=%b K=%b",
                 n_txn, rst_n, en, up, load, d, q, q_n, tc, dut.j_bus, dut.k_bus);
        chk("Q", q, x.q);
        chk("Q_n", q_n, ~x.q);
        chk("TC", {3'b000, tc}, {3'b000, x.tc});
        chk("J", dut.j_bus, x.j);
        chk("K", dut.k_bus, x.k);
      end
    end
  end

  initial begin : stimulus
    n_checks = 0; n_fail = 0; n_txn = 0; model_q = 0;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;

    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    // Up count with wrap: 1..9,0,1,2
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    // Reach 7, then reset mid-count with EN low
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    // Down wrap from 1
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    // Load priority and clamping
    step(1, 1, 1, 1, 5);
    step(1, 1, 0, 1, 12);
    step(1, 0, 1, 0, 0);
    // Hold at 4, then alternate direction every edge
    step(1, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    // Reset together with a load request discards the load
    step(0, 1, 1, 1, 6);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL provide parameter MOD, default 10, count modulus; legal range 2..2^WIDTH.
REQ-003 CLK  input  1  clock; all state updates on its rising edge.
REQ-004 RST_n  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  count enable.
REQ-006 UP  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 LOAD  input  1  synchronous parallel load request.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  current count.
REQ-010 Q_n  output  WIDTH  bitwise complement of Q, always.
REQ-011 TC  output  1  terminal-count flag, combinational.

Function
REQ-012 SHALL hold each count bit in one JK storage cell; per-bit J/K SHALL be generated by next-state logic. J=K=0 holds, J=0/K=1 clears, J=1/K=0 sets, J=K=1 toggles.
REQ-013 SHALL use priority LOAD > EN > hold on each rising CLK edge.
REQ-014 LOAD=1: Q SHALL become D on the same edge when D < MOD, else MOD-1; each bit is driven J=d, K=~d.
REQ-015 LOAD=0, EN=1, UP=1: Q SHALL become Q+1, or 0 when Q == MOD-1.
REQ-016 LOAD=0, EN=1, UP=0: Q SHALL become Q-1, or MOD-1 when Q == 0.
REQ-017 LOAD=0, EN=0: Q SHALL hold, all J=K=0.
REQ-018 Non-wrapping increments/decrements SHALL use toggle on bit i when all lower bits are 1 (up) or 0 (down); wrap transitions SHALL use explicit set/clear per bit.
REQ-019 TC SHALL be 1 iff EN=1, LOAD=0, and either (UP=1, Q==MOD-1) or (UP=0, Q==0).
REQ-020 Latency: a count, load, or direction effect SHALL appear on Q one CLK edge after the qualifying inputs; TC SHALL follow inputs with zero latency.
REQ-021 If Q holds an illegal value >= MOD, the next enabled count SHALL load 0 when UP=1 and MOD-1 when UP=0.
REQ-022 A change of UP while EN=1 SHALL take effect on the next edge with no idle cycle.
REQ-023 Q_n SHALL never equal Q in any bit, including during reset.

Reset
REQ-024 RST_n=0 SHALL immediately force Q=0 and Q_n=all ones, independent of CLK.
REQ-025 While RST_n=0, TC SHALL follow REQ-019 with Q=0.
REQ-026 Reset assertion mid-count or mid-load SHALL discard the pending update; the first post-release edge SHALL act on the current inputs from Q=0.

Structure
REQ-027 A shared package SHALL hold the JK action encoding constants (HOLD=00, CLR=01, SET=10, TGL=11) and the default WIDTH/MOD values.
REQ-028 SHALL instantiate one sub-module, jk_cell, WIDTH times; it has CLK, RST_n, J, K, Q, Q_n and resets to Q=0/Q_n=1.
REQ-029 J/K generation, clamping, and TC logic SHALL live in the top level; no other state elements are permitted.

Verification
REQ-030 Reset: assert RST_n=0 mid-count at Q=7 -> Q=0 and Q_n=4'hF without a CLK edge; TC=0 with EN=0.
REQ-031 Up wrap: MOD=10, EN=1, UP=1 for 12 edges from 0 -> sequence 1..9,0,1,2; TC=1 only while Q=9.
REQ-032 Down wrap: EN=1, UP=0 from Q=1 -> Q=0 with TC=1, then Q=9, then Q=8.
REQ-033 Load priority: LOAD=1, EN=1, D=5 -> Q=5 next edge; D=12 -> Q=9; TC=0 during LOAD.
REQ-034 Hold/direction: EN=0 for 3 edges at Q=4 -> Q stays 4; then EN=1 and toggle UP each edge -> 5,4,5.
REQ-035 Every test SHALL check Q_n == ~Q on each cycle and that each jk_cell receives J/K matching REQ-014..REQ-018.
